// File: rtl/stopwatch_lap_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : stopwatch_lap_timer
// Brief    : Run/pause stopwatch, up/down modulo-MAX count, FWFT lap FIFO.
//            Optional preload ports enabled by macro STOPWATCH_PRESET_EN.
// Revision : 1.0
// ============================================================================
module stopwatch_lap_timer #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX        = 99,
  parameter int LAP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  dir,
  input  logic                  lap,
  input  logic                  lap_rd,
`ifdef STOPWATCH_PRESET_EN
  input  logic                  preload,
  input  logic [DATA_WIDTH-1:0] preload_value,
`endif
  output logic [DATA_WIDTH-1:0] count,
  output logic                  running,
  output logic                  wrap,
  output logic [DATA_WIDTH-1:0] lap_data,
  output logic                  lap_valid,
  output logic                  lap_full,
  output logic                  lap_ovf
);

  localparam int PTR_W = $clog2(LAP_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [DATA_WIDTH-1:0] c_MAX   = DATA_WIDTH'(MAX);
  localparam logic [OCC_W-1:0]      c_DEPTH = OCC_W'(LAP_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_step;
  logic                  w_wrap_now;
  logic [DATA_WIDTH-1:0] w_step_val;
  logic                  w_preload;
  logic [DATA_WIDTH-1:0] w_preload_val;

  logic [DATA_WIDTH-1:0] r_count;
  logic                  r_running;
  logic                  r_wrap;

  logic [DATA_WIDTH-1:0] r_mem [LAP_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic [DATA_WIDTH-1:0] r_lap_data;
  logic                  r_lap_valid;
  logic                  r_lap_full;
  logic                  r_lap_ovf;

  logic                  w_push_req;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ovf_set;
  logic [OCC_W-1:0]      w_occ_nxt;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;
  logic [PTR_W-1:0]      w_wr_ptr_nxt;
  logic [DATA_WIDTH-1:0] w_head_nxt;

`ifdef STOPWATCH_PRESET_EN
  assign w_preload     = preload;
  assign w_preload_val = (preload_value > c_MAX) ? c_MAX : preload_value;
`else
  assign w_preload     = 1'b0;
  assign w_preload_val = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = S_RUN;
          w_step      = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) w_state_nxt = S_PAUSE;
        else      w_step      = 1'b1;
      end
      S_PAUSE: begin
        if (start && !stop) begin
          w_state_nxt = S_RUN;
          w_step      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_wrap_now = dir ? (r_count == '0) : (r_count == c_MAX);
    if (dir) w_step_val = (r_count == '0)  ? c_MAX : r_count - DATA_WIDTH'(1);
    else     w_step_val = (r_count == c_MAX) ? '0  : r_count + DATA_WIDTH'(1);
  end

  // Preload freezes state and suppresses the step (and hence the wrap pulse).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (w_preload) begin
      r_count <= w_preload_val;
      r_wrap  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == S_RUN);
      r_wrap    <= w_step && w_wrap_now;
      if (w_step) r_count <= w_step_val;
    end
  end

  always_comb begin
    w_push_req   = lap && (r_state != S_IDLE);
    w_full       = (r_occ == c_DEPTH);
    w_pop        = lap_rd && (r_occ != '0);
    w_push       = w_push_req && (!w_full || w_pop);
    w_ovf_set    = w_push_req && w_full && !w_pop;
    w_rd_ptr_nxt = w_pop  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    w_wr_ptr_nxt = w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
    w_occ_nxt    = r_occ;
    if (w_push && !w_pop)      w_occ_nxt = r_occ + OCC_W'(1);
    else if (!w_push && w_pop) w_occ_nxt = r_occ - OCC_W'(1);
    // The next head is the value being written only when it lands in the head slot.
    if (w_occ_nxt == '0)                          w_head_nxt = '0;
    else if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = r_count;
    else                                          w_head_nxt = r_mem[w_rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= r_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_lap_data  <= '0;
      r_lap_valid <= 1'b0;
      r_lap_full  <= 1'b0;
      r_lap_ovf   <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_occ       <= w_occ_nxt;
      r_lap_data  <= w_head_nxt;
      r_lap_valid <= (w_occ_nxt != '0);
      r_lap_full  <= (w_occ_nxt == c_DEPTH);
      if (w_ovf_set) r_lap_ovf <= 1'b1;
    end
  end

  assign count     = r_count;
  assign running   = r_running;
  assign wrap      = r_wrap;
  assign lap_data  = r_lap_data;
  assign lap_valid = r_lap_valid;
  assign lap_full  = r_lap_full;
  assign lap_ovf   = r_lap_ovf;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_lap_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_stopwatch_lap_timer
// Brief    : Directed scoreboard bench for stopwatch_lap_timer.
// Revision : 1.0
// ============================================================================
module tb_stopwatch_lap_timer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, start, stop, dir, lap, lap_rd;
`ifdef STOPWATCH_PRESET_EN
  logic          preload;
  logic [DW-1:0] preload_value;
`endif
  logic [DW-1:0] count, lap_data;
  logic          running, wrap, lap_valid, lap_full, lap_ovf;

  stopwatch_lap_timer #(.DATA_WIDTH(DW), .MAX(99), .LAP_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir),
    .lap(lap), .lap_rd(lap_rd),
`ifdef STOPWATCH_PRESET_EN
    .preload(preload), .preload_value(preload_value),
`endif
    .count(count), .running(running), .wrap(wrap), .lap_data(lap_data),
    .lap_valid(lap_valid), .lap_full(lap_full), .lap_ovf(lap_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    int            cyc;
    logic [DW-1:0] cnt;
    logic          run, wr;
    logic [DW-1:0] ld;
    logic          lv, lf, ov;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs for a given cycle are compared at the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_checks++;
      if (e.cyc != cyc || count !== e.cnt || running !== e.run || wrap !== e.wr ||
          lap_data !== e.ld || lap_valid !== e.lv || lap_full !== e.lf || lap_ovf !== e.ov) begin
        n_errors++;
        $display("FAIL %s cyc=%0d/%0d: got cnt=%0d run=%0b wrap=%0b ld=%0d lv=%0b lf=%0b ovf=%0b want cnt=%0d run=%0b wrap=%0b ld=%0d lv=%0b lf=%0b ovf=%0b",
                 e.name, cyc, e.cyc, count, running, wrap, lap_data, lap_valid, lap_full, lap_ovf,
                 e.cnt, e.run, e.wr, e.ld, e.lv, e.lf, e.ov);
      end
    end
  end

  task automatic expect_out(input string nm, input int cnt, input bit run, input bit wr,
                            input int ld, input bit lv, input bit lf, input bit ov);
    exp_t e;
    e.name = nm; e.cyc = cyc + 1; e.cnt = DW'(cnt); e.run = run; e.wr = wr;
    e.ld = DW'(ld); e.lv = lv; e.lf = lf; e.ov = ov;
    q.push_back(e);
  endtask

  task automatic step(input bit rs, input bit st, input bit sp, input bit d,
                      input bit lp, input bit rd);
    reset = rs; start = st; stop = sp; dir = d; lap = lp; lap_rd = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit d);
    repeat (n) step(1'b0, 1'b0, 1'b0, d, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; lap = 1'b0; lap_rd = 1'b0;
`ifdef STOPWATCH_PRESET_EN
    preload = 1'b0; preload_value = '0;
`endif
    @(posedge clk); #1;

    // Reset and first steps
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0);          step(1, 0, 0, 0, 0, 0);
    expect_out("start_step", 1, 1, 0, 0, 0, 0, 0);     step(0, 1, 0, 0, 0, 0);
    for (int i = 2; i <= 6; i++) begin
      expect_out($sformatf("up_%0d", i), i, 1, 0, 0, 0, 0, 0);
      idle(1, 0);
    end

    // Up wrap at MAX, then down wrap at 0
    idle(92, 0);
    expect_out("up_99", 99, 1, 0, 0, 0, 0, 0);         idle(1, 0);
    expect_out("up_wrap", 0, 1, 1, 0, 0, 0, 0);        idle(1, 0);
    expect_out("up_after_wrap", 1, 1, 0, 0, 0, 0, 0);  idle(1, 0);
    expect_out("down_0", 0, 1, 0, 0, 0, 0, 0);         idle(1, 1);
    expect_out("down_wrap", 99, 1, 1, 0, 0, 0, 0);     idle(1, 1);
    expect_out("down_98", 98, 1, 0, 0, 0, 0, 0);       idle(1, 1);

    // stop has priority over start; lap honoured in PAUSE; resume steps at once
    expect_out("stop_start", 98, 0, 0, 0, 0, 0, 0);    step(0, 1, 1, 0, 0, 0);
    expect_out("pause_lap", 98, 0, 0, 98, 1, 0, 0);    step(0, 0, 0, 0, 1, 0);
    expect_out("resume", 99, 1, 0, 98, 1, 0, 0);       step(0, 1, 0, 0, 0, 0);
    expect_out("resume_wrap", 0, 1, 1, 98, 1, 0, 0);   idle(1, 0);

    // Fill FIFO with 10,20,30,40 and overflow with 50
    expect_out("reset2", 0, 0, 0, 0, 0, 0, 0);         step(1, 0, 0, 0, 0, 0);
    expect_out("start2", 1, 1, 0, 0, 0, 0, 0);         step(0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      idle(9, 0);
      expect_out($sformatf("lap_%0d", k * 10), k * 10 + 1, 1, 0, 10, 1, k >= 4, k == 5);
      step(0, 0, 0, 0, 1, 0);
    end
    expect_out("pop_10", 52, 1, 0, 20, 1, 0, 1);       step(0, 0, 0, 0, 0, 1);
    expect_out("pop_20", 53, 1, 0, 30, 1, 0, 1);       step(0, 0, 0, 0, 0, 1);
    expect_out("pop_30", 54, 1, 0, 40, 1, 0, 1);       step(0, 0, 0, 0, 0, 1);
    expect_out("pop_40", 55, 1, 0, 0, 0, 0, 1);        step(0, 0, 0, 0, 0, 1);
    expect_out("pop_empty", 56, 1, 0, 0, 0, 0, 1);     step(0, 0, 0, 0, 0, 1);

    // Two laps stored, then reset mid-run; lap in IDLE ignored
    expect_out("lap_56", 57, 1, 0, 56, 1, 0, 1);       step(0, 0, 0, 0, 1, 0);
    expect_out("lap_57", 58, 1, 0, 56, 1, 0, 1);       step(0, 0, 0, 0, 1, 0);
    expect_out("reset_midrun", 0, 0, 0, 0, 0, 0, 0);   step(1, 1, 0, 0, 1, 1);
    expect_out("idle_lap", 0, 0, 0, 0, 0, 0, 0);       step(0, 0, 0, 0, 1, 0);

    // Full FIFO with simultaneous push and pop
    expect_out("start3", 1, 1, 0, 0, 0, 0, 0);         step(0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      idle(9, 0);
      expect_out($sformatf("fill_%0d", k * 10), k * 10 + 1, 1, 0, 10, 1, k == 4, 0);
      step(0, 0, 0, 0, 1, 0);
    end
    expect_out("full_push_pop", 42, 1, 0, 20, 1, 1, 0); step(0, 0, 0, 0, 1, 1);
    expect_out("drain_20", 43, 1, 0, 30, 1, 0, 0);      step(0, 0, 0, 0, 0, 1);
    expect_out("drain_30", 44, 1, 0, 40, 1, 0, 0);      step(0, 0, 0, 0, 0, 1);
    expect_out("drain_40", 45, 1, 0, 41, 1, 0, 0);      step(0, 0, 0, 0, 0, 1);
    expect_out("drain_41", 46, 1, 0, 0, 0, 0, 0);       step(0, 0, 0, 0, 0, 1);

`ifdef STOPWATCH_PRESET_EN
    preload = 1'b1; preload_value = DW'(150);
    expect_out("preload_clamp", 99, 1, 0, 0, 0, 0, 0);  idle(1, 0);
    preload = 1'b0;
    expect_out("preload_then_wrap", 0, 1, 1, 0, 0, 0, 0); idle(1, 0);
`endif

    @(negedge clk); #1;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
